cam_pattern_source: RTL and testbench

CAM_PATTERN_SOURCE -- requirements
Module: cam_pattern_source

---
 rtl/cam_src_pkg.sv | 26 ++
 rtl/cam_pattern_source_if.sv | 29 ++
 rtl/cam_src_timing.sv | 152 +++++++++++++++
 rtl/cam_pattern_source.sv | 98 +++++++++
 tb/tb_cam_pattern_source.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cam_src_pkg.sv
// Shared types and constants for the camera test-pattern source:
// FSM state encoding, luma/chroma constants and the colour-bar luma table.
package cam_src_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBLANK = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_HBLANK = 3'd4
    } cam_state_e;

    localparam logic [7:0] Y_WHITE   = 8'hEB;
    localparam logic [7:0] Y_BLACK   = 8'h10;
    localparam logic [7:0] C_NEUTRAL = 8'h80;

    // Left-to-right bar luma, white down to black.
    localparam logic [7:0] BAR_LUMA [8] = '{
        8'hEB, 8'hD2, 8'hAA, 8'h91, 8'h6A, 8'h51, 8'h29, 8'h10
    };

    function automatic logic [7:0] bar_luma(input logic [2:0] idx);
        return BAR_LUMA[idx];
    endfunction

endpackage

// File: rtl/cam_pattern_source_if.sv
// Pixel-byte output bus of the camera pattern source, plus FSM state for observation.
interface cam_pattern_source_if;
    import cam_src_pkg::*;

    // No backpressure: o_data carries a valid byte on every p_clk where o_h_sync
    // is high; the sink must accept every byte, and o_data is 0 whenever o_h_sync is low.
    logic       o_h_sync;
    logic       o_v_sync;
    logic       o_frame_done;
    logic [7:0] o_data;
    cam_state_e dbg_state;

    modport master (
        output o_h_sync,
        output o_v_sync,
        output o_frame_done,
        output o_data,
        output dbg_state
    );

    modport slave (
        input o_h_sync,
        input o_v_sync,
        input o_frame_done,
        input o_data,
        input dbg_state
    );

endinterface

// File: rtl/cam_src_timing.sv
// Frame timing for the pattern source: FSM, cycle/line/x/y/frame counters and
// registered sync outputs; exposes next-cycle pixel coordinates for the data path.
module cam_src_timing
    import cam_src_pkg::*;
#(
    parameter int FrameWidth        = 640,
    parameter int FrameHeight       = 480,
    parameter int ActiveFrameWidth  = 512,
    parameter int ActiveFrameHeight = 384,
    parameter int VSyncLines        = 3,
    parameter int XW                = $clog2(ActiveFrameWidth),
    parameter int YW                = $clog2(ActiveFrameHeight)
) (
    input  logic          p_clk,
    input  logic          RST,
    input  logic          i_enable,
    output cam_state_e    o_state,
    output logic          o_h_sync,
    output logic          o_v_sync,
    output logic          o_frame_done,
    output logic          o_frame_start,
    output logic          o_pix_active,
    output logic          o_pix_byte,
    output logic [XW-1:0] o_pix_x,
    output logic [YW-1:0] o_pix_y,
    output logic [15:0]   o_frame_cnt
);

    localparam int LINE_CYC  = 2 * FrameWidth;
    localparam int ACT_CYC   = 2 * ActiveFrameWidth;
    localparam int VBL_LINES = FrameHeight - ActiveFrameHeight - VSyncLines;
    localparam int CW        = $clog2(LINE_CYC);
    localparam int LW        = $clog2(FrameHeight);

    localparam logic [CW-1:0] CYC_LINE_LAST = CW'(LINE_CYC - 1);
    localparam logic [CW-1:0] CYC_ACT_LAST  = CW'(ACT_CYC - 1);
    localparam logic [LW-1:0] VS_LAST       = LW'(VSyncLines - 1);
    localparam logic [LW-1:0] VB_LAST       = LW'(VBL_LINES - 1);
    localparam logic [YW-1:0] Y_LAST        = YW'(ActiveFrameHeight - 1);

    cam_state_e    state, state_nxt;
    logic [CW-1:0] cyc, cyc_nxt;
    logic [LW-1:0] line_cnt, line_nxt;
    logic [XW-1:0] x, x_nxt;
    logic [YW-1:0] y, y_nxt;
    logic [15:0]   frame_cnt, frame_cnt_nxt;
    logic          h_nxt, v_nxt, done_nxt, start_nxt;
    logic          line_end;

    assign line_end = (cyc == CYC_LINE_LAST);

    // State register; sync outputs are registered from next-cycle values so they
    // line up with the state they describe.
    always_ff @(posedge p_clk) begin
        if (!RST) begin
            state        <= ST_IDLE;
            cyc          <= '0;
            line_cnt     <= '0;
            x            <= '0;
            y            <= '0;
            frame_cnt    <= '0;
            o_h_sync     <= 1'b0;
            o_v_sync     <= 1'b0;
            o_frame_done <= 1'b0;
        end else begin
            state        <= state_nxt;
            cyc          <= cyc_nxt;
            line_cnt     <= line_nxt;
            x            <= x_nxt;
            y            <= y_nxt;
            frame_cnt    <= frame_cnt_nxt;
            o_h_sync     <= h_nxt;
            o_v_sync     <= v_nxt;
            o_frame_done <= done_nxt;
        end
    end

    always_comb begin : next_state
        state_nxt     = state;
        cyc_nxt       = cyc;
        line_nxt      = line_cnt;
        x_nxt         = x;
        y_nxt         = y;
        frame_cnt_nxt = frame_cnt;
        case (state)
            ST_IDLE: begin
                if (i_enable) begin
                    state_nxt = ST_VSYNC;
                    cyc_nxt   = '0;
                    line_nxt  = '0;
                end
            end
            ST_VSYNC, ST_VBLANK: begin
                cyc_nxt = line_end ? '0 : cyc + CW'(1);
                if (line_end) begin
                    line_nxt = line_cnt + LW'(1);
                    if (state == ST_VSYNC && line_cnt == VS_LAST) begin
                        state_nxt = ST_VBLANK;
                        line_nxt  = '0;
                    end else if (state == ST_VBLANK && line_cnt == VB_LAST) begin
                        state_nxt = ST_ACTIVE;
                        line_nxt  = '0;
                        x_nxt     = '0;
                        y_nxt     = '0;
                    end
                end
            end
            ST_ACTIVE: begin
                cyc_nxt = cyc + CW'(1);
                if (cyc == CYC_ACT_LAST) begin
                    state_nxt = ST_HBLANK;
                    x_nxt     = '0;
                end else if (cyc[0]) begin
                    x_nxt = x + XW'(1);
                end
            end
            ST_HBLANK: begin
                cyc_nxt = line_end ? '0 : cyc + CW'(1);
                if (line_end) begin
                    if (y == Y_LAST) begin
                        // End of frame: an enable dropped mid-frame takes effect only here.
                        y_nxt         = '0;
                        frame_cnt_nxt = frame_cnt + 16'd1;
                        state_nxt     = i_enable ? ST_VSYNC : ST_IDLE;
                    end else begin
                        y_nxt     = y + YW'(1);
                        state_nxt = ST_ACTIVE;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin : outputs
        v_nxt     = (state_nxt == ST_VSYNC);
        h_nxt     = (state_nxt == ST_ACTIVE);
        done_nxt  = (state_nxt == ST_HBLANK) && (cyc_nxt == CYC_LINE_LAST) && (y_nxt == Y_LAST);
        start_nxt = (state_nxt == ST_VSYNC) && (state != ST_VSYNC);
    end

    assign o_state       = state;
    assign o_frame_start = start_nxt;
    assign o_pix_active  = h_nxt;
    assign o_pix_byte    = cyc_nxt[0];
    assign o_pix_x       = x_nxt;
    assign o_pix_y       = y_nxt;
    assign o_frame_cnt   = frame_cnt;

endmodule

// File: rtl/cam_pattern_source.sv
// Camera test-pattern source emitting YUV 4:2:2 bytes (bars, ramp, checker, flat).
// Define CAM_SRC_STAMP_EN to overwrite pixel x=0 of each line with {y, frame_cnt}.
module cam_pattern_source
    import cam_src_pkg::*;
#(
    parameter int FrameWidth        = 640,
    parameter int FrameHeight       = 480,
    parameter int ActiveFrameWidth  = 512,
    parameter int ActiveFrameHeight = 384,
    parameter int VSyncLines        = 3
) (
    input  logic                    p_clk,
    input  logic                    RST,
    input  logic                    i_enable,
    input  logic [1:0]              i_pattern_sel,
    cam_pattern_source_if.master    vid
);

    localparam int XW    = $clog2(ActiveFrameWidth);
    localparam int YW    = $clog2(ActiveFrameHeight);
    localparam int BAR_W = ActiveFrameWidth / 8;

    cam_state_e    state;
    logic          h_sync, v_sync, frame_done, frame_start;
    logic          pix_active, pix_byte;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;
    logic [15:0]   frame_cnt;
    logic [15:0]   x16, y16;
    logic [1:0]    pat;
    logic [7:0]    luma, byte_nxt, data_q;
    logic          unused_bits;

    cam_src_timing #(
        .FrameWidth        (FrameWidth),
        .FrameHeight       (FrameHeight),
        .ActiveFrameWidth  (ActiveFrameWidth),
        .ActiveFrameHeight (ActiveFrameHeight),
        .VSyncLines        (VSyncLines)
    ) u_timing (
        .p_clk         (p_clk),
        .RST           (RST),
        .i_enable      (i_enable),
        .o_state       (state),
        .o_h_sync      (h_sync),
        .o_v_sync      (v_sync),
        .o_frame_done  (frame_done),
        .o_frame_start (frame_start),
        .o_pix_active  (pix_active),
        .o_pix_byte    (pix_byte),
        .o_pix_x       (pix_x),
        .o_pix_y       (pix_y),
        .o_frame_cnt   (frame_cnt)
    );

    assign x16         = 16'(pix_x);
    assign y16         = 16'(pix_y);
    assign unused_bits = ^{frame_cnt[15:8], y16};

    always_comb begin
        case (pat)
            2'd0:    luma = bar_luma(3'(x16 / 16'(BAR_W)));
            2'd1:    luma = x16[7:0];
            2'd2:    luma = (x16[5] ^ y16[5]) ? Y_WHITE : Y_BLACK;
            default: luma = frame_cnt[7:0];
        endcase
        // Byte 1 is U for even x and V for odd x; both are neutral in every pattern.
        byte_nxt = pix_byte ? C_NEUTRAL : luma;
`ifdef CAM_SRC_STAMP_EN
        if (x16 == 16'd0) begin
            byte_nxt = pix_byte ? frame_cnt[7:0] : y16[7:0];
        end
`endif
        if (!pix_active) begin
            byte_nxt = 8'h00;
        end
    end

    // Pattern is latched only as a frame enters VSYNC so a frame never mixes patterns.
    always_ff @(posedge p_clk) begin
        if (!RST) begin
            pat    <= 2'd0;
            data_q <= 8'h00;
        end else begin
            if (frame_start) begin
                pat <= i_pattern_sel;
            end
            data_q <= byte_nxt;
        end
    end

    assign vid.o_h_sync     = h_sync;
    assign vid.o_v_sync     = v_sync;
    assign vid.o_frame_done = frame_done;
    assign vid.o_data       = data_q;
    assign vid.dbg_state    = state;

endmodule

// File: tb/tb_cam_pattern_source.sv
// Self-checking bench for cam_pattern_source on a reduced frame geometry.
module tb_cam_pattern_source;
    import cam_src_pkg::*;

    localparam int FW    = 72;
    localparam int FH    = 44;
    localparam int AFW   = 64;
    localparam int AFH   = 36;
    localparam int VS    = 3;
    localparam int VBL   = FH - AFH - VS;
    localparam int LINE  = 2 * FW;
    localparam int ACT   = 2 * AFW;
    localparam int FRAME = FH * LINE;
    localparam int ASTART = (VS + VBL) * LINE;
    localparam logic [63:0] BARS = 64'hEBD2AA91_6A512910;

    logic       p_clk = 1'b0;
    logic       RST = 1'b0;
    logic       i_enable = 1'b0;
    logic [1:0] i_pattern_sel = 2'd0;

    cam_pattern_source_if vid();

    cam_pattern_source #(
        .FrameWidth        (FW),
        .FrameHeight       (FH),
        .ActiveFrameWidth  (AFW),
        .ActiveFrameHeight (AFH),
        .VSyncLines        (VS)
    ) dut (
        .p_clk         (p_clk),
        .RST           (RST),
        .i_enable      (i_enable),
        .i_pattern_sel (i_pattern_sel),
        .vid           (vid)
    );

    // clock / cycle count
    always #5 p_clk = ~p_clk;
    int cyc_now = 0;
    always @(posedge p_clk) cyc_now <= cyc_now + 1;

    int total = 0;
    int bad = 0;
    int fcnt_model = 0;
    logic [10:0] exp_q[$];
    logic [7:0]  obs_d [FRAME];
    logic        obs_h [FRAME];
    logic        obs_v [FRAME];
    int          done_q[$];
    logic [7:0]  flat_y[$];

    // Reference: expected {v_sync, h_sync, frame_done, data} at offset t from the first VSYNC cycle.
    function automatic logic [10:0] model_out(input int t, input int pat, input int fc);
        int line, col, x, y;
        logic v, h, dn;
        logic [7:0] d;
        logic [63:0] bars;
        bars = BARS;
        line = t / LINE;
        col  = t % LINE;
        v  = (line < VS);
        h  = (line >= VS + VBL) && (col < ACT);
        dn = (t == FRAME - 1);
        d  = 8'h00;
        if (h) begin
            x = col / 2;
            y = line - VS - VBL;
            if (col % 2 == 1) d = 8'h80;
            else begin
                case (pat)
                    0:       d = bars[63 - 8 * (x / (AFW / 8)) -: 8];
                    1:       d = 8'(x % 256);
                    2:       d = ((((x / 32) % 2) ^ ((y / 32) % 2)) != 0) ? 8'hEB : 8'h10;
                    default: d = 8'(fc % 256);
                endcase
            end
`ifdef CAM_SRC_STAMP_EN
            if (x == 0) d = (col % 2 == 1) ? 8'(fc % 256) : 8'(y % 256);
`endif
        end
        return {v, h, dn, d};
    endfunction

    // Driver: starts from IDLE at a negedge, runs n frames back to back, checks every cycle.
    task automatic run_frames(input int n, input int fixed_pat, input int drop_t);
        int pat;
        logic [10:0] exp, obs;
        pat = (fixed_pat < 0) ? int'($urandom_range(0, 3)) : fixed_pat;
        i_pattern_sel = 2'(pat);
        i_enable = 1'b1;
        for (int f = 0; f < n; f++) begin
            for (int t = 0; t < FRAME; t++) exp_q.push_back(model_out(t, pat, fcnt_model));
            for (int t = 0; t < FRAME; t++) begin
                @(negedge p_clk);
                exp = exp_q.pop_front();
                obs = {vid.o_v_sync, vid.o_h_sync, vid.o_frame_done, vid.o_data};
                total++;
                if (obs !== exp) begin
                    bad++;
                    $display("FAIL stream pat=%0d f=%0d t=%0d got=%h want=%h", pat, f, t, obs, exp);
                end
                obs_d[t] = vid.o_data;
                obs_h[t] = vid.o_h_sync;
                obs_v[t] = vid.o_v_sync;
                if (vid.o_frame_done === 1'b1) done_q.push_back(cyc_now);
                if (t == ASTART + 2) flat_y.push_back(vid.o_data);
                if (t == FRAME - 1) begin
                    fcnt_model++;
                    if (f == n - 1) i_enable = 1'b0;
                    else begin
                        pat = (fixed_pat < 0) ? int'($urandom_range(0, 3)) : fixed_pat;
                        i_pattern_sel = 2'(pat);
                    end
                end else begin
                    i_pattern_sel = 2'($urandom_range(0, 3));
                    if (drop_t >= 0 && t >= drop_t) i_enable = 1'b0;
                end
            end
        end
    endtask

    task automatic idle_check(input int k, input string tag);
        for (int i = 0; i < k; i++) begin
            @(negedge p_clk);
            total++;
            if ({vid.o_v_sync, vid.o_h_sync, vid.o_frame_done, vid.o_data} !== 11'd0) begin
                bad++;
                $display("FAIL %s i=%0d got=%b%b%b/%h want=000/00", tag, i,
                         vid.o_v_sync, vid.o_h_sync, vid.o_frame_done, vid.o_data);
            end
        end
    endtask

    task automatic test_reset();
        RST = 1'b0;
        i_enable = 1'b1;
        repeat (3) @(negedge p_clk);
        total += 5;
        if (vid.o_v_sync !== 1'b0) begin bad++; $display("FAIL reset_v got=%b want=0", vid.o_v_sync); end
        if (vid.o_h_sync !== 1'b0) begin bad++; $display("FAIL reset_h got=%b want=0", vid.o_h_sync); end
        if (vid.o_frame_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", vid.o_frame_done); end
        if (vid.o_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", vid.o_data); end
        if (vid.dbg_state !== ST_IDLE) begin bad++; $display("FAIL reset_state got=%0d want=0", vid.dbg_state); end
        i_enable = 1'b0;
        RST = 1'b1;
        idle_check(5, "idle_after_reset");
        fcnt_model = 0;
    endtask

    task automatic test_first_frame();
        int vcnt, first_h, hcnt;
        run_frames(1, 0, -1);
        vcnt = 0; first_h = -1; hcnt = 0;
        for (int t = 0; t < FRAME; t++) begin
            if (obs_v[t]) vcnt++;
            if (obs_h[t] && first_h < 0) first_h = t;
        end
        for (int t = ASTART; t < ASTART + LINE; t++) if (obs_h[t]) hcnt++;
        total += 8;
        if (obs_v[0] !== 1'b1) begin bad++; $display("FAIL vsync_rise got=%b want=1", obs_v[0]); end
        if (vcnt != VS * LINE) begin bad++; $display("FAIL vsync_len got=%0d want=%0d", vcnt, VS * LINE); end
        if (first_h + 1 != 1 + ASTART) begin bad++; $display("FAIL first_hsync got=%0d want=%0d", first_h + 1, 1 + ASTART); end
        if (hcnt != ACT || obs_h[ASTART + ACT - 1] !== 1'b1 || obs_h[ASTART + ACT] !== 1'b0) begin
            bad++; $display("FAIL hsync_line got=%0d want=%0d", hcnt, ACT);
        end
        if (obs_d[ASTART + 2] !== 8'hEB) begin bad++; $display("FAIL bar0_y got=%h want=eb", obs_d[ASTART + 2]); end
        if (obs_d[ASTART + 3] !== 8'h80) begin bad++; $display("FAIL bar0_c got=%h want=80", obs_d[ASTART + 3]); end
        if (obs_d[ASTART + 2 * (AFW / 8) - 2] !== 8'hEB) begin
            bad++; $display("FAIL bar0_end got=%h want=eb", obs_d[ASTART + 2 * (AFW / 8) - 2]);
        end
        if (obs_d[ASTART + 2 * (AFW / 8)] !== 8'hD2) begin
            bad++; $display("FAIL bar1_start got=%h want=d2", obs_d[ASTART + 2 * (AFW / 8)]);
        end
        idle_check(5, "idle_after_frame");
    endtask

    task automatic test_checker();
        run_frames(1, 2, -1);
        total += 2;
        if (obs_d[ASTART + 64] !== 8'hEB) begin bad++; $display("FAIL chk_y0_x32 got=%h want=eb", obs_d[ASTART + 64]); end
        if (obs_d[ASTART + 32 * LINE + 64] !== 8'h10) begin
            bad++; $display("FAIL chk_y32_x32 got=%h want=10", obs_d[ASTART + 32 * LINE + 64]);
        end
`ifdef CAM_SRC_STAMP_EN
        total += 2;
        if (obs_d[ASTART + 5 * LINE] !== 8'h05) begin bad++; $display("FAIL stamp_y got=%h want=05", obs_d[ASTART + 5 * LINE]); end
        if (obs_d[ASTART + 5 * LINE + 1] !== 8'h01) begin bad++; $display("FAIL stamp_f got=%h want=01", obs_d[ASTART + 5 * LINE + 1]); end
`endif
        idle_check(3, "idle_after_checker");
    endtask

    task automatic test_enable_drop();
        done_q.delete();
        run_frames(1, -1, FRAME / 2);
        total++;
        if (done_q.size() != 1) begin bad++; $display("FAIL drop_done_count got=%0d want=1", done_q.size()); end
        idle_check(2 * LINE, "idle_after_drop");
    endtask

    task automatic test_reset_mid_line();
        int stop_t;
        stop_t = ASTART + 3 * LINE + 40;
        i_pattern_sel = 2'd1;
        i_enable = 1'b1;
        for (int t = 0; t <= stop_t; t++) @(negedge p_clk);
        total++;
        if (vid.o_h_sync !== 1'b1) begin bad++; $display("FAIL midline_h got=%b want=1", vid.o_h_sync); end
        RST = 1'b0;
        @(negedge p_clk);
        total += 4;
        if (vid.o_v_sync !== 1'b0) begin bad++; $display("FAIL rst_mid_v got=%b want=0", vid.o_v_sync); end
        if (vid.o_h_sync !== 1'b0) begin bad++; $display("FAIL rst_mid_h got=%b want=0", vid.o_h_sync); end
        if (vid.o_frame_done !== 1'b0) begin bad++; $display("FAIL rst_mid_done got=%b want=0", vid.o_frame_done); end
        if (vid.o_data !== 8'h00) begin bad++; $display("FAIL rst_mid_data got=%h want=00", vid.o_data); end
        RST = 1'b1;
        i_enable = 1'b0;
        fcnt_model = 0;
        idle_check(10, "idle_after_rst_mid");
    endtask

    task automatic test_flat();
        done_q.delete();
        flat_y.delete();
        run_frames(3, 3, -1);
        total += 2;
        if (done_q.size() != 3) begin bad++; $display("FAIL flat_done_count got=%0d want=3", done_q.size()); end
        if (flat_y.size() != 3) begin bad++; $display("FAIL flat_samples got=%0d want=3", flat_y.size()); end
        for (int i = 0; i < 3 && i < flat_y.size(); i++) begin
            total++;
            if (flat_y[i] !== 8'(i)) begin bad++; $display("FAIL flat_y f=%0d got=%h want=%h", i, flat_y[i], 8'(i)); end
        end
        for (int i = 1; i < done_q.size(); i++) begin
            total++;
            if (done_q[i] - done_q[i-1] != FRAME) begin
                bad++; $display("FAIL done_period got=%0d want=%0d", done_q[i] - done_q[i-1], FRAME);
            end
        end
        idle_check(3, "idle_after_flat");
    endtask

    task automatic test_back_to_back();
        run_frames(2, -1, -1);
        idle_check(3, "idle_after_b2b");
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_checker();
        test_enable_drop();
        test_reset_mid_line();
        test_flat();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
